// File: rtl/control_unit.sv
// Multi-cycle control unit for a LEGv8-style datapath.
// Steps a FETCH / EXEC / LOADWB state machine and decodes the held instruction
// register into the 37-bit control word plus the 32-bit immediate k.
module control_unit #(
    parameter int CUL = 36
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [31:0]   IR,
    input  logic [3:0]    status,
    output logic [CUL:0]  controlWord,
    output logic [31:0]   k
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        EXEC   = 4'd1,
        LOADWB = 4'd2
    } state_t;

    state_t      r_state;

    // Decoded control fields
    logic [4:0]  w_da;
    logic [4:0]  w_sa;
    logic [4:0]  w_sb;
    logic [4:0]  w_fs;
    logic        w_c0;
    logic        w_regWrite;
    logic        w_bSel;
    logic        w_memWrite;
    logic        w_memRead;
    logic [1:0]  w_dataSel;
    logic        w_sl;
    logic [1:0]  w_ps;
    logic        w_il;
    logic        w_addrSel;
    state_t      w_ns;
    logic [31:0] w_k;
    logic [36:0] w_word;

    // ALU operation shared by R-type and I-type arithmetic/logic instructions
    logic [4:0]  w_aluFs;
    logic        w_aluC0;
    logic        w_aluSl;

    // Branch condition evaluation
    logic        w_condTrue;
    logic        w_flagV;
    logic        w_flagC;
    logic        w_flagN;
    logic        w_flagZ;

    // Instruction class detection
    logic        w_isRType;
    logic        w_isIType;
    logic        w_isLdur;
    logic        w_isStur;
    logic        w_isB;
    logic        w_isCbz;
    logic        w_isCbnz;
    logic        w_isBcond;
    logic        w_isBr;

    // Sign-extended immediates for the memory and branch formats
    logic [31:0] w_kMem;
    logic [31:0] w_kCond;
    logic [31:0] w_kBranch;
    logic [31:0] w_kArith;

    assign w_isRType = IR[31] && (IR[28:25] == 4'b0101) && (IR[23:21] == 3'b000);
    assign w_isIType = IR[31] && ((IR[28:25] == 4'b1000) || (IR[28:25] == 4'b1001));
    assign w_isLdur  = (IR[31:21] == 11'b11111000010);
    assign w_isStur  = (IR[31:21] == 11'b11111000000);
    assign w_isB     = (IR[31:26] == 6'b000101);
    assign w_isCbz   = (IR[31:24] == 8'b10110100);
    assign w_isCbnz  = (IR[31:24] == 8'b10110101);
    assign w_isBcond = (IR[31:24] == 8'b01010100);
    assign w_isBr    = (IR[31:21] == 11'b11010110000);

    assign w_kMem    = {{23{IR[20]}}, IR[20:12]};
    assign w_kCond   = {{11{IR[23]}}, IR[23:5], 2'b00};
    assign w_kBranch = {{4{IR[25]}}, IR[25:0], 2'b00};
    assign w_kArith  = {20'b0, IR[21:10]};

    assign w_flagV = status[3];
    assign w_flagC = status[2];
    assign w_flagN = status[1];
    assign w_flagZ = status[0];

    // Map the {IR[30:29],IR[24]} op select onto function select, carry-in and flag load
    always_comb begin
        w_aluFs = 5'b00000;
        w_aluC0 = 1'b0;
        w_aluSl = 1'b0;
        case ({IR[30:29], IR[24]})
            3'b001: w_aluFs = 5'b01000;
            3'b011: begin w_aluFs = 5'b01000; w_aluSl = 1'b1; end
            3'b101: begin w_aluFs = 5'b01010; w_aluC0 = 1'b1; end
            3'b111: begin w_aluFs = 5'b01010; w_aluC0 = 1'b1; w_aluSl = 1'b1; end
            3'b000: w_aluFs = 5'b00000;
            3'b010: w_aluFs = 5'b00100;
            3'b100: w_aluFs = 5'b01100;
            3'b110: begin w_aluFs = 5'b00000; w_aluSl = 1'b1; end
            default: w_aluFs = 5'b00000;
        endcase
    end

    // Evaluate the ARM condition code in IR[3:0] against the registered flags
    always_comb begin
        w_condTrue = 1'b0;
        case (IR[3:0])
            4'b0000: w_condTrue = w_flagZ;
            4'b0001: w_condTrue = !w_flagZ;
            4'b0010: w_condTrue = w_flagC;
            4'b0011: w_condTrue = !w_flagC;
            4'b0100: w_condTrue = w_flagN;
            4'b0101: w_condTrue = !w_flagN;
            4'b0110: w_condTrue = w_flagV;
            4'b0111: w_condTrue = !w_flagV;
            4'b1000: w_condTrue = w_flagC && !w_flagZ;
            4'b1001: w_condTrue = !(w_flagC && !w_flagZ);
            4'b1010: w_condTrue = (w_flagN == w_flagV);
            4'b1011: w_condTrue = (w_flagN != w_flagV);
            4'b1100: w_condTrue = !w_flagZ && (w_flagN == w_flagV);
            4'b1101: w_condTrue = !(!w_flagZ && (w_flagN == w_flagV));
            default: w_condTrue = 1'b1;
        endcase
    end

    // Decode state and instruction into the individual control fields and next state
    always_comb begin
        w_da       = 5'd0;
        w_sa       = 5'd0;
        w_sb       = 5'd0;
        w_fs       = 5'd0;
        w_c0       = 1'b0;
        w_regWrite = 1'b0;
        w_bSel     = 1'b0;
        w_memWrite = 1'b0;
        w_memRead  = 1'b0;
        w_dataSel  = 2'b00;
        w_sl       = 1'b0;
        w_ps       = 2'b00;
        w_il       = 1'b0;
        w_addrSel  = 1'b0;
        w_ns       = FETCH;
        w_k        = 32'd0;
        case (r_state)
            FETCH: begin
                w_il      = 1'b1;
                w_ps      = 2'b01;
                w_memRead = 1'b1;
                w_ns      = EXEC;
            end
            EXEC: begin
                if (w_isRType) begin
                    w_da       = IR[4:0];
                    w_sa       = IR[9:5];
                    w_sb       = IR[20:16];
                    w_fs       = w_aluFs;
                    w_c0       = w_aluC0;
                    w_sl       = w_aluSl;
                    w_regWrite = 1'b1;
                end else if (w_isIType) begin
                    w_da       = IR[4:0];
                    w_sa       = IR[9:5];
                    w_fs       = w_aluFs;
                    w_c0       = w_aluC0;
                    w_sl       = w_aluSl;
                    w_bSel     = 1'b1;
                    w_regWrite = 1'b1;
                    w_k        = w_kArith;
                end else if (w_isLdur) begin
                    w_sa      = IR[9:5];
                    w_bSel    = 1'b1;
                    w_fs      = 5'b01000;
                    w_addrSel = 1'b1;
                    w_memRead = 1'b1;
                    w_k       = w_kMem;
                    w_ns      = LOADWB;
                end else if (w_isStur) begin
                    w_sa       = IR[9:5];
                    w_sb       = IR[4:0];
                    w_bSel     = 1'b1;
                    w_fs       = 5'b01000;
                    w_addrSel  = 1'b1;
                    w_memWrite = 1'b1;
                    w_k        = w_kMem;
                end else if (w_isB) begin
                    w_ps = 2'b10;
                    w_k  = w_kBranch;
                end else if (w_isCbz || w_isCbnz) begin
                    w_sa = IR[4:0];
                    w_sb = 5'd31;
                    w_fs = 5'b01000;
                    w_k  = w_kCond;
                    w_ps = ((w_isCbz && w_flagZ) || (w_isCbnz && !w_flagZ)) ? 2'b10 : 2'b00;
                end else if (w_isBcond) begin
                    w_k  = w_kCond;
                    w_ps = w_condTrue ? 2'b10 : 2'b00;
                end else if (w_isBr) begin
                    w_sa = IR[9:5];
                    w_ps = 2'b11;
                end
            end
            LOADWB: begin
                w_da       = IR[4:0];
                w_sa       = IR[9:5];
                w_bSel     = 1'b1;
                w_fs       = 5'b01000;
                w_addrSel  = 1'b1;
                w_memRead  = 1'b1;
                w_dataSel  = 2'b01;
                w_regWrite = 1'b1;
                w_k        = w_kMem;
            end
            default: w_ns = FETCH;
        endcase
    end

    assign w_word = {w_da, w_sa, w_sb, w_fs, w_c0, w_regWrite, w_bSel, w_memWrite,
                     w_memRead, w_dataSel, w_sl, w_ps, w_il, w_addrSel, w_ns, 1'b0};

    // Outputs are forced to zero for as long as reset is held low
    assign controlWord = reset ? w_word[CUL:0] : '0;
    assign k           = reset ? w_k : 32'd0;

    // Advance the state machine; reset drops straight back to FETCH
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_ns;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed testbench for control_unit: walks instructions through FETCH/EXEC
// and compares the control word and immediate against hand-built values.
module tb_control_unit;

    logic        clock;
    logic        reset;
    logic [31:0] IR;
    logic [3:0]  status;
    logic [36:0] controlWord;
    logic [31:0] k;

    int checks = 0;
    int errors = 0;

    logic [36:0] fetchCw;

    control_unit #(.CUL(36)) dut (
        .clock       (clock),
        .reset       (reset),
        .IR          (IR),
        .status      (status),
        .controlWord (controlWord),
        .k           (k)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Assemble a control word from its individual fields
    function automatic logic [36:0] cw(
        input logic [4:0] da, input logic [4:0] sa, input logic [4:0] sb,
        input logic [4:0] fs, input logic c0, input logic rw, input logic bsel,
        input logic mw, input logic mr, input logic [1:0] dsel, input logic sl,
        input logic [1:0] ps, input logic il, input logic asel, input logic [3:0] ns);
        return {da, sa, sb, fs, c0, rw, bsel, mw, mr, dsel, sl, ps, il, asel, ns, 1'b0};
    endfunction

    task automatic applyStimulus(input logic [31:0] ir, input logic [3:0] st);
        IR     = ir;
        status = st;
        #1;
    endtask

    task automatic nextCycle;
        @(negedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [36:0] expCw, input logic [31:0] expK);
        checks++;
        assert (controlWord === expCw) else begin
            errors++;
            $error("[TB] FAIL %s controlWord: observed %h expected %h", tag, controlWord, expCw);
        end
        checks++;
        assert (k === expK) else begin
            errors++;
            $error("[TB] FAIL %s k: observed %h expected %h", tag, k, expK);
        end
    endtask

    // Fetch, execute and return to FETCH for a single-cycle-execute instruction
    task automatic runInstr(input string tag, input logic [31:0] ir, input logic [3:0] st,
                            input logic [36:0] expCw, input logic [31:0] expK);
        applyStimulus(ir, st);
        checkOutput({tag, "_fetch"}, fetchCw, 32'd0);
        nextCycle();
        checkOutput(tag, expCw, expK);
        nextCycle();
    endtask

    initial begin
        fetchCw = cw(5'd0, 5'd0, 5'd0, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                     2'b00, 1'b0, 2'b01, 1'b1, 1'b0, 4'd1);
        reset  = 1'b0;
        IR     = {11'b10001011000, 5'd1, 6'd0, 5'd0, 5'd2};
        status = 4'b0000;

        // Held in reset across a rising edge
        @(negedge clock);
        #1;
        checkOutput("reset_held", 37'd0, 32'd0);

        // Release and land in FETCH
        @(negedge clock);
        reset = 1'b1;
        #1;
        checkOutput("fetch_after_reset", fetchCw, 32'd0);

        // ADD X2,X0,X1
        nextCycle();
        checkOutput("add", cw(5'd2, 5'd0, 5'd1, 5'b01000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                              2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0), 32'd0);
        nextCycle();
        checkOutput("add_back_to_fetch", fetchCw, 32'd0);

        runInstr("subs", {11'b11101011000, 5'd5, 6'd0, 5'd4, 5'd3}, 4'b0000,
                 cw(5'd3, 5'd4, 5'd5, 5'b01010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                    2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 4'd0), 32'd0);
        runInstr("ands", {11'b11101010000, 5'd8, 6'd0, 5'd7, 5'd6}, 4'b0000,
                 cw(5'd6, 5'd7, 5'd8, 5'b00000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                    2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 4'd0), 32'd0);
        runInstr("eor", {11'b11001010000, 5'd3, 6'd0, 5'd2, 5'd1}, 4'b0000,
                 cw(5'd1, 5'd2, 5'd3, 5'b01100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                    2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0), 32'd0);
        runInstr("addi", {10'b1001000100, 12'h123, 5'd10, 5'd9}, 4'b0000,
                 cw(5'd9, 5'd10, 5'd0, 5'b01000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                    2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0), 32'h0000_0123);

        // LDUR X1,[X2,#-8] takes an extra LOADWB cycle
        applyStimulus({11'b11111000010, 9'h1F8, 2'b00, 5'd2, 5'd1}, 4'b0000);
        checkOutput("ldur_fetch", fetchCw, 32'd0);
        nextCycle();
        checkOutput("ldur_exec", cw(5'd0, 5'd2, 5'd0, 5'b01000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
                                    2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 4'd2), 32'hFFFF_FFF8);
        nextCycle();
        checkOutput("ldur_loadwb", cw(5'd1, 5'd2, 5'd0, 5'b01000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
                                      2'b01, 1'b0, 2'b00, 1'b0, 1'b1, 4'd0), 32'hFFFF_FFF8);
        nextCycle();

        runInstr("stur", {11'b11111000000, 9'd16, 2'b00, 5'd4, 5'd3}, 4'b0000,
                 cw(5'd0, 5'd4, 5'd3, 5'b01000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
                    2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 4'd0), 32'd16);
        runInstr("cbz_taken", {8'b10110100, 19'd4, 5'd7}, 4'b0001,
                 cw(5'd0, 5'd7, 5'd31, 5'b01000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                    2'b00, 1'b0, 2'b10, 1'b0, 1'b0, 4'd0), 32'h0000_0010);
        runInstr("cbz_not_taken", {8'b10110100, 19'd4, 5'd7}, 4'b0000,
                 cw(5'd0, 5'd7, 5'd31, 5'b01000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                    2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0), 32'h0000_0010);
        runInstr("cbnz_taken", {8'b10110101, 19'd4, 5'd7}, 4'b0000,
                 cw(5'd0, 5'd7, 5'd31, 5'b01000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                    2'b00, 1'b0, 2'b10, 1'b0, 1'b0, 4'd0), 32'h0000_0010);
        runInstr("b_back", {6'b000101, 26'h3FF_FFFF}, 4'b0000,
                 cw(5'd0, 5'd0, 5'd0, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                    2'b00, 1'b0, 2'b10, 1'b0, 1'b0, 4'd0), 32'hFFFF_FFFC);
        runInstr("bge_taken", {8'b01010100, 19'd2, 1'b0, 4'b1010}, 4'b1010,
                 cw(5'd0, 5'd0, 5'd0, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                    2'b00, 1'b0, 2'b10, 1'b0, 1'b0, 4'd0), 32'd8);
        runInstr("blt_not_taken", {8'b01010100, 19'd2, 1'b0, 4'b1011}, 4'b1010,
                 cw(5'd0, 5'd0, 5'd0, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                    2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0), 32'd8);
        runInstr("bhi_taken", {8'b01010100, 19'd2, 1'b0, 4'b1000}, 4'b0100,
                 cw(5'd0, 5'd0, 5'd0, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                    2'b00, 1'b0, 2'b10, 1'b0, 1'b0, 4'd0), 32'd8);
        runInstr("br", {11'b11010110000, 5'd31, 6'd0, 5'd30, 5'd0}, 4'b0000,
                 cw(5'd0, 5'd30, 5'd0, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                    2'b00, 1'b0, 2'b11, 1'b0, 1'b0, 4'd0), 32'd0);
        runInstr("nop_unknown", 32'h0000_0000, 4'b0000, 37'd0, 32'd0);

        // Reset asserted in the middle of an EXEC cycle
        applyStimulus({11'b10001011000, 5'd1, 6'd0, 5'd0, 5'd2}, 4'b0000);
        nextCycle();
        checkOutput("add_before_abort", cw(5'd2, 5'd0, 5'd1, 5'b01000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                                           2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0), 32'd0);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("reset_mid_exec", 37'd0, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        checkOutput("fetch_after_abort", fetchCw, 32'd0);
        nextCycle();
        checkOutput("add_after_abort", cw(5'd2, 5'd0, 5'd1, 5'b01000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                                          2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
